// File: rtl/serial_compare_ctrl_pkg.sv
// Shared types for the serial 2-bit-slice comparator.
// State encodings and result-vector bit positions.
package serial_compare_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int R_EQ = 0;
    localparam int R_LT = 1;
    localparam int R_GT = 2;

endpackage

// File: rtl/serial_compare_ctrl_cmp2_slice.sv
// Combinational 2-bit unsigned magnitude comparator.
// Compares {A,B} against {C,D}.
module cmp2_slice (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic EQ,
    output logic LT,
    output logic GT
);

    logic [1:0] ab;
    logic [1:0] cd;

    // Exactly one of EQ/LT/GT is high for any input.
    always_comb begin
        ab = {A, B};
        cd = {C, D};
        EQ = (ab == cd);
        LT = (ab < cd);
        GT = (ab > cd);
    end

endmodule

// File: rtl/serial_compare_ctrl.sv
// Serial MSB-first operand compare using one 2-bit slice.
// Stops at the first unequal slice; pulses DONE with flags.
module serial_compare_ctrl
    import serial_compare_ctrl_pkg::*;
#(
    parameter  int WIDTH  = 8,
    localparam int SLICES = WIDTH / 2,
    localparam int CW     = $clog2(SLICES + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] OP_X,
    input  logic [WIDTH-1:0] OP_Y,
    output logic             BUSY,
    output logic             DONE,
    output logic             EQ,
    output logic             LT,
    output logic             GT,
    output logic [CW-1:0]    SLICE_CNT
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sx_q;
    logic [WIDTH-1:0] sy_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       res_q;
    logic             done_q;

    logic             s_eq;
    logic             s_lt;
    logic             s_gt;
    logic             last;
    logic             decide;

    cmp2_slice u_slice (
        .A  (sx_q[WIDTH-1]),
        .B  (sx_q[WIDTH-2]),
        .C  (sy_q[WIDTH-1]),
        .D  (sy_q[WIDTH-2]),
        .EQ (s_eq),
        .LT (s_lt),
        .GT (s_gt)
    );

    // Decision point: unequal slice, or equal on the final slice.
    always_comb begin
        last   = (cnt_q == CW'(SLICES - 1));
        decide = (state_q == ST_COMPARE)
               && (s_lt || s_gt || (s_eq && last));
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; START is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (START) state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (decide) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand shifters, slice counter, result flags and DONE pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sx_q   <= '0;
            sy_q   <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= decide;
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        sx_q  <= OP_X;
                        sy_q  <= OP_Y;
                        cnt_q <= '0;
                        res_q <= '0;
                    end
                end
                ST_COMPARE: begin
                    cnt_q <= cnt_q + CW'(1);
                    unique case (1'b1)
                        s_gt: res_q[R_GT] <= 1'b1;
                        s_lt: res_q[R_LT] <= 1'b1;
                        s_eq: begin
                            if (last) begin
                                res_q[R_EQ] <= 1'b1;
                            end else begin
                                sx_q <= sx_q << 2;
                                sy_q <= sy_q << 2;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Outputs: BUSY decoded from state, the rest registered.
    always_comb begin
        BUSY      = (state_q != ST_IDLE);
        DONE      = done_q;
        EQ        = res_q[R_EQ];
        LT        = res_q[R_LT];
        GT        = res_q[R_GT];
        SLICE_CNT = cnt_q;
    end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl (WIDTH=8 and WIDTH=2).
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_compare_ctrl;

    localparam logic [2:0] F_EQ = 3'b001;
    localparam logic [2:0] F_LT = 3'b010;
    localparam logic [2:0] F_GT = 3'b100;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] op_x;
    logic [7:0] op_y;
    logic       busy;
    logic       done;
    logic       eq;
    logic       lt;
    logic       gt;
    logic [2:0] cnt;

    logic       start2;
    logic [1:0] x2;
    logic [1:0] y2;
    logic       busy2;
    logic       done2;
    logic       eq2;
    logic       lt2;
    logic       gt2;
    logic [0:0] cnt2;

    int checks;
    int errors;

    serial_compare_ctrl #(.WIDTH(8)) dut8 (
        .CLK       (clk),
        .RESET     (reset),
        .START     (start),
        .OP_X      (op_x),
        .OP_Y      (op_y),
        .BUSY      (busy),
        .DONE      (done),
        .EQ        (eq),
        .LT        (lt),
        .GT        (gt),
        .SLICE_CNT (cnt)
    );

    serial_compare_ctrl #(.WIDTH(2)) dut2 (
        .CLK       (clk),
        .RESET     (reset),
        .START     (start2),
        .OP_X      (x2),
        .OP_Y      (y2),
        .BUSY      (busy2),
        .DONE      (done2),
        .EQ        (eq2),
        .LT        (lt2),
        .GT        (gt2),
        .SLICE_CNT (cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full compare on the 8-bit DUT. k = slices examined.
    // inj != 0: re-assert START with other operands in that cycle.
    task automatic compare(input logic [7:0] x,
                           input logic [7:0] y,
                           input logic [2:0] exp_f,
                           input int k,
                           input int inj);
        op_x  = x;
        op_y  = y;
        start = 1'b1;
        for (int c = 1; c <= k + 2; c++) begin
            @(negedge clk);
            if (c == inj) begin
                start = 1'b1;
                op_x  = 8'h00;
                op_y  = 8'hFF;
            end else begin
                start = 1'b0;
            end
            check("done", 32'(done), 32'(c == k + 1));
            check("busy", 32'(busy), 32'(c <= k + 1));
            if (c <= k) begin
                check("flags_pre", 32'({gt, lt, eq}), 32'd0);
                check("cnt_run", 32'(cnt), 32'(c - 1));
            end else begin
                check("flags", 32'({gt, lt, eq}), 32'(exp_f));
                check("cnt", 32'(cnt), 32'(k));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op_x   = 8'h00;
        op_y   = 8'h00;
        start2 = 1'b0;
        x2     = 2'd0;
        y2     = 2'd0;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", 32'({gt, lt, eq}), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);

        @(negedge clk);
        compare(8'hA5, 8'hA5, F_EQ, 4, 0);
        compare(8'h80, 8'h7F, F_GT, 1, 0);
        compare(8'h3C, 8'h3D, F_LT, 4, 0);
        compare(8'h3C, 8'h2C, F_GT, 2, 0);
        compare(8'h00, 8'hFF, F_LT, 1, 0);
        compare(8'hFE, 8'hFF, F_LT, 4, 0);
        compare(8'hA5, 8'hA5, F_EQ, 4, 2);

        // Flags held through IDLE until the next START.
        @(negedge clk);
        check("hold_eq", 32'({gt, lt, eq}), 32'(F_EQ));
        check("hold_cnt", 32'(cnt), 32'd4);

        // Synchronous reset in cycle 2 aborts the compare.
        op_x  = 8'hA5;
        op_y  = 8'hA5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_flags", 32'({gt, lt, eq}), 32'd0);
        check("abort_cnt", 32'(cnt), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_nodone", 32'(done), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
        end
        compare(8'h01, 8'h02, F_LT, 4, 0);

        // START held high: re-accepted right after DONE.
        op_x  = 8'h80;
        op_y  = 8'h7F;
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 6) start = 1'b0;
            check("b2b_done", 32'(done), 32'(c == 2 || c == 5));
            check("b2b_busy", 32'(busy), 32'(c != 3 && c != 6));
            if (c == 4) check("b2b_clr", 32'({gt, lt, eq}), 32'd0);
            if (c == 5) check("b2b_gt", 32'({gt, lt, eq}), 32'(F_GT));
        end
        @(negedge clk);
        check("b2b_stop", 32'(busy), 32'd0);

        // WIDTH=2: all operand pairs against a behavioural model.
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                logic [2:0] m;
                m = (x > y) ? F_GT : ((x < y) ? F_LT : F_EQ);
                x2     = 2'(x);
                y2     = 2'(y);
                start2 = 1'b1;
                @(negedge clk);
                start2 = 1'b0;
                check("w2_c1_done", 32'(done2), 32'd0);
                check("w2_c1_busy", 32'(busy2), 32'd1);
                @(negedge clk);
                check("w2_done", 32'(done2), 32'd1);
                check("w2_flags", 32'({gt2, lt2, eq2}), 32'(m));
                check("w2_cnt", 32'(cnt2), 32'd1);
                @(negedge clk);
                check("w2_idle", 32'(busy2), 32'd0);
                check("w2_hold", 32'({gt2, lt2, eq2}), 32'(m));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
